// File: rtl/pulse_receiver_duration_capture.sv
// Measures constant-level segments on an asynchronous line in prescaled ticks and
// presents each finished segment as a {level, duration, idle} symbol on a valid/ready register.
module pulse_receiver_duration_capture #(
  parameter int unsigned PRESCALER_WIDTH = 16,
  parameter int unsigned TIMER_WIDTH     = 8
) (
  input  logic                               clk,
  input  logic                               sys_rst_n,
  input  logic                               en,
  input  logic                               invert,
  input  logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler,
  input  logic [TIMER_WIDTH-1:0]             idle_threshold,
  input  logic                               sig_in,
  output logic                               data_valid,
  input  logic                               data_ready,
  output logic                               data_level,
  output logic [TIMER_WIDTH-1:0]             data_duration,
  output logic                               data_idle,
  output logic                               overflow,
  input  logic                               overflow_clr
);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                     state_q, state_d;
  logic                       sync1_q, sync2_q, level_q;
  logic                       sig_s, sig_edge;
  logic [PRESCALER_WIDTH-1:0] pre_q, pre_d, pre_reload;
  logic [TIMER_WIDTH-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                       tick, timeout;
  logic                       push, push_level, push_idle;
  logic [TIMER_WIDTH-1:0]     push_dur;
  logic                       valid_q, valid_d, level_out_q, level_out_d;
  logic                       idle_out_q, idle_out_d, ovf_q, ovf_d;
  logic [TIMER_WIDTH-1:0]     dur_q, dur_d;
  logic                       accept, load, drop;

  assign sig_s      = sync2_q ^ invert;
  assign sig_edge   = sig_s != level_q;
  assign pre_reload = (PRESCALER_WIDTH'(1) << prescaler) - PRESCALER_WIDTH'(1);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + TIMER_WIDTH'(1);
  assign tick       = en && (state_q == StMeasure) && !sig_edge && (pre_q == '0);
  // Guard on cnt_q keeps a saturated count from re-firing the timeout every tick.
  assign timeout    = tick && (idle_threshold != '0) && (cnt_inc == idle_threshold) &&
                      (cnt_q != idle_threshold);

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (sig_edge) state_d = StMeasure;
        StMeasure: if (!sig_edge && timeout) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Output logic: symbol push requests
  always_comb begin
    push       = 1'b0;
    push_level = level_q;
    push_dur   = cnt_q;
    push_idle  = 1'b0;
    if (en && (state_q == StMeasure)) begin
      if (sig_edge) begin
        push = 1'b1;
      end else if (timeout) begin
        push      = 1'b1;
        push_dur  = idle_threshold;
        push_idle = 1'b1;
      end
    end
  end

  // Prescaler and duration counters
  always_comb begin
    pre_d = '0;
    cnt_d = '0;
    if (en) begin
      if (sig_edge) begin
        pre_d = pre_reload;
      end else if (state_q == StMeasure) begin
        if (pre_q == '0) begin
          pre_d = pre_reload;
          cnt_d = cnt_inc;
        end else begin
          pre_d = pre_q - PRESCALER_WIDTH'(1);
          cnt_d = cnt_q;
        end
      end
    end
  end

  // One-entry output register; a push into a full, stalled register is dropped.
  always_comb begin
    accept      = valid_q && data_ready;
    load        = push && (!valid_q || data_ready);
    drop        = push && valid_q && !data_ready;
    valid_d     = valid_q;
    level_out_d = level_out_q;
    dur_d       = dur_q;
    idle_out_d  = idle_out_q;
    ovf_d       = ovf_q;
    if (accept) valid_d = 1'b0;
    if (load) begin
      valid_d     = 1'b1;
      level_out_d = push_level;
      dur_d       = push_dur;
      idle_out_d  = push_idle;
    end
    if (overflow_clr) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      pre_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      level_out_q <= 1'b0;
      dur_q       <= '0;
      idle_out_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sig_in;
      sync2_q     <= sync1_q;
      level_q     <= sig_s;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      level_out_q <= level_out_d;
      dur_q       <= dur_d;
      idle_out_q  <= idle_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign data_valid    = valid_q;
  assign data_level    = level_out_q;
  assign data_duration = dur_q;
  assign data_idle     = idle_out_q;
  assign overflow      = ovf_q;

endmodule
